// File: rtl/lenet_buffer_reader.sv
// rtl/lenet_buffer_reader.sv - streams the padded LeNet input buffer to the CNN engine
// One pass per data_ready: raster-order RAM reads feed a 2-entry skid FIFO behind px_valid/px_ready.
module lenet_buffer_reader #(
  parameter int BUF_DIM = 32,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8
) (
  input  logic              i_clk25,
  input  logic              i_rst,
  input  logic              i_data_ready,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_px_valid,
  input  logic              i_px_ready,
  output logic [DATA_W-1:0] o_px_data,
  output logic              o_px_row_end,
  output logic              o_px_last,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_overrun
);

  localparam int HALF = ADDR_W / 2;
  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(BUF_DIM * BUF_DIM - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W:0]     r_issue_cnt;
  logic                r_inflight;
  logic                r_infl_row_end;
  logic                r_infl_last;
  logic [DATA_W+1:0]   r_mem [2];
  logic                r_wr_ptr;
  logic                r_rd_ptr;
  logic [1:0]          r_count;
  logic                r_pending;
  logic                r_overrun;

  logic                w_pop;
  logic                w_push;
  logic [2:0]          w_occ;
  logic                w_issue;
  logic                w_start;
  logic [DATA_W+1:0]   w_head;

  assign w_head       = r_mem[r_rd_ptr];
  assign o_px_valid   = (r_count != 2'd0);
  assign o_px_data    = w_head[DATA_W+1:2];
  assign o_px_row_end = w_head[1];
  assign o_px_last    = w_head[0];
  assign o_rd_addr    = r_issue_cnt[ADDR_W-1:0];
  assign o_overrun    = r_overrun;

  assign w_pop   = o_px_valid && i_px_ready;
  assign w_push  = r_inflight;
  assign w_start = (r_state == S_IDLE) && (i_data_ready || r_pending);

  // Entries already buffered or on the RAM bus; a pop this cycle frees a slot for the new read.
  assign w_occ   = {1'b0, r_count} + {2'b00, r_inflight};
  assign w_issue = (r_state == S_READ) && ((w_occ < 3'd2) || (w_pop && (w_occ == 3'd2)));

  always_comb begin
    w_state_nxt = r_state;
    o_rd_en     = 1'b0;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (w_start) w_state_nxt = S_READ;
      end
      S_READ: begin
        o_rd_en = w_issue;
        if (w_issue && (r_issue_cnt == LAST_ADDR)) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_pop && o_px_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk25) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_issue_cnt    <= '0;
      r_inflight     <= 1'b0;
      r_infl_row_end <= 1'b0;
      r_infl_last    <= 1'b0;
      r_mem[0]       <= '0;
      r_mem[1]       <= '0;
      r_wr_ptr       <= 1'b0;
      r_rd_ptr       <= 1'b0;
      r_count        <= 2'd0;
      r_pending      <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_issue;

      if (w_start) begin
        r_issue_cnt <= '0;
      end else if (w_issue) begin
        r_issue_cnt <= r_issue_cnt + 1'b1;
      end

      if (w_issue) begin
        r_infl_row_end <= &r_issue_cnt[HALF-1:0];
        r_infl_last    <= (r_issue_cnt == LAST_ADDR);
      end

      if (w_push) begin
        r_mem[r_wr_ptr] <= {i_rd_data, r_infl_row_end, r_infl_last};
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase

      // In IDLE a start consumes the pending request; a coincident data_ready re-arms it.
      if (r_state == S_IDLE) begin
        r_pending <= r_pending & i_data_ready;
      end else if (i_data_ready) begin
        if (r_pending) r_overrun <= 1'b1;
        else           r_pending <= 1'b1;
      end
    end
  end

endmodule
